// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator running at half the system clock.
// Ports: clk, rst (sync, active high), en (run enable) in;
//        hsync, vsync (active low), video_on, pix_tick, x, y, line_start,
//        frame_start, frame_cnt out.
// Optional feature: define VGA_FRAME_CNT_EN to build the 8-bit frame counter;
// without it frame_cnt is tied to zero.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic step;
    logic x_wrap;
    logic y_wrap;

    // A pixel advances on the clk edge where pix_tick is already high.
    // rst overrides en, so no end-of-line pulse can appear in a reset cycle.
    assign step   = en & pix_tick & ~rst;
    assign x_wrap = (x == H_MAX);
    assign y_wrap = (y == V_MAX);

    assign line_start  = step & x_wrap;
    assign frame_start = line_start & y_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_tick <= 1'b0;
            x        <= '0;
            y        <= '0;
        end else if (en) begin
            pix_tick <= ~pix_tick;
            if (pix_tick) begin
                if (x_wrap) begin
                    x <= '0;
                    y <= y_wrap ? 10'd0 : y + 10'd1;
                end else begin
                    x <= x + 10'd1;
                end
            end
        end
    end

    // One compare per bound straight off the registered counters.
    assign hsync    = ~((x >= HS_BEG) & (x < HS_END));
    assign vsync    = ~((y >= VS_BEG) & (y < VS_END));
    assign video_on = (x < H_VIS) & (y < V_VIS);

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else if (frame_start) begin
            frame_q <= frame_q + 8'd1;
        end
    end

    assign frame_cnt = frame_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule
